// File: rtl/std_lane_tx_framer.sv
// std_lane_tx_framer
//
// Per-lane transmitter that feeds one PE execution lane. Raw source words
// are buffered in a small FIFO and tagged with stream framing control
// (SOM single word, SOD first, MOD middle, EOD last) derived from the
// programmed transfer length. The FIFO head drives the PE lane under
// valid/ready flow control. A completion pulse follows the handshake of
// the final word.
//
// Optional feature macro: STD_LANE_TX_PARITY_EN
//   defined   -> each FIFO entry carries an even-parity bit over {cntl,data},
//                computed at write time and presented on tx__pe__parity.
//   undefined -> no parity storage, tx__pe__parity tied low.
//
// Ports:
//   clk                    lane clock, rising-edge state updates
//   reset_poweron          synchronous active-high reset
//   cfg__tx__start         one-cycle pulse, begins a transfer
//   cfg__tx__num_of_words  transfer length, sampled with start
//   tx__cfg__busy          high from accepted start until the complete pulse
//   tx__cfg__complete      one-cycle pulse after the last word reaches the PE
//   tx__cfg__error         one-cycle pulse after a rejected start
//   src__tx__valid/data    source word stream
//   tx__src__ready         framer accepts a source word this cycle
//   tx__pe__valid/cntl/data/parity  lane word towards the PE
//   pe__tx__ready          PE lane accepts the word
module std_lane_tx_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    input  logic                  cfg__tx__start,
    input  logic [LEN_WIDTH-1:0]  cfg__tx__num_of_words,
    output logic                  tx__cfg__busy,
    output logic                  tx__cfg__complete,
    output logic                  tx__cfg__error,
    input  logic                  src__tx__valid,
    input  logic [DATA_WIDTH-1:0] src__tx__data,
    output logic                  tx__src__ready,
    output logic                  tx__pe__valid,
    output logic [1:0]            tx__pe__cntl,
    output logic [DATA_WIDTH-1:0] tx__pe__data,
    output logic                  tx__pe__parity,
    input  logic                  pe__tx__ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
`ifdef STD_LANE_TX_PARITY_EN
    localparam int ENTRY_W = DATA_WIDTH + 3;
`else
    localparam int ENTRY_W = DATA_WIDTH + 2;
`endif

    localparam logic [1:0] CNTL_SOM = 2'b00;
    localparam logic [1:0] CNTL_SOD = 2'b01;
    localparam logic [1:0] CNTL_MOD = 2'b10;
    localparam logic [1:0] CNTL_EOD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   in_cnt_q, in_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   busy_q, busy_d;
    logic                   complete_q, complete_d;
    logic                   error_q, error_d;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   last_pop;
    logic [1:0]             wr_cntl;
    logic [ENTRY_W-1:0]     wr_entry;
    logic [ENTRY_W-1:0]     head;

    assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
    assign fifo_empty = (occ_q == '0);

    // Ready is combinational from registered state so a full FIFO stalls the
    // source in the same cycle; push and pop on a full FIFO cannot coincide.
    assign tx__src__ready = (state_q == ST_FILL) && !fifo_full && (in_cnt_q < len_q);
    assign push           = src__tx__valid && tx__src__ready;

    assign head          = mem_q[rd_ptr_q];
    assign tx__pe__valid = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) && !fifo_empty;
    // Head fields are masked while invalid so the lane sees zeros, not stale memory.
    assign tx__pe__cntl  = tx__pe__valid ? head[DATA_WIDTH+1:DATA_WIDTH] : 2'b00;
    assign tx__pe__data  = tx__pe__valid ? head[DATA_WIDTH-1:0] : '0;
`ifdef STD_LANE_TX_PARITY_EN
    assign tx__pe__parity = tx__pe__valid ? head[ENTRY_W-1] : 1'b0;
`else
    assign tx__pe__parity = 1'b0;
`endif

    assign pop      = tx__pe__valid && pe__tx__ready;
    // A SOM or EOD tag marks the final word of the transfer.
    assign last_pop = pop && ((tx__pe__cntl == CNTL_SOM) || (tx__pe__cntl == CNTL_EOD));

    always_comb begin
        wr_cntl = CNTL_MOD;
        if (len_q == LEN_WIDTH'(1)) begin
            wr_cntl = CNTL_SOM;
        end else if (in_cnt_q == '0) begin
            wr_cntl = CNTL_SOD;
        end else if (in_cnt_q == len_q - LEN_WIDTH'(1)) begin
            wr_cntl = CNTL_EOD;
        end
    end

`ifdef STD_LANE_TX_PARITY_EN
    assign wr_entry = {^{wr_cntl, src__tx__data}, wr_cntl, src__tx__data};
`else
    assign wr_entry = {wr_cntl, src__tx__data};
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        in_cnt_d   = in_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        busy_d     = busy_q;
        complete_d = 1'b0;
        error_d    = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (cfg__tx__start) begin
                    if (cfg__tx__num_of_words == '0) begin
                        error_d = 1'b1;
                    end else begin
                        len_d    = cfg__tx__num_of_words;
                        in_cnt_d = '0;
                        busy_d   = 1'b1;
                        state_d  = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                error_d = cfg__tx__start;
                if (push) begin
                    in_cnt_d = in_cnt_q + LEN_WIDTH'(1);
                    if (in_cnt_q + LEN_WIDTH'(1) == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
                if (last_pop) begin
                    complete_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DRAIN: begin
                error_d = cfg__tx__start;
                if (last_pop) begin
                    complete_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                error_d = cfg__tx__start;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            in_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            in_cnt_q   <= in_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            error_q    <= error_d;
        end
    end

    // Storage needs no reset: entries are only read while occupancy says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign tx__cfg__busy     = busy_q;
    assign tx__cfg__complete = complete_q;
    assign tx__cfg__error    = error_q;

endmodule

// File: tb/tb_std_lane_tx_framer.sv
// Testbench for std_lane_tx_framer: scoreboard of expected lane words built
// from the framing rules, with a monitor that checks every PE handshake,
// output stability under back-pressure and completion pulse timing.
module tb_std_lane_tx_framer;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset_poweron;
    logic          cfg__tx__start;
    logic [LW-1:0] cfg__tx__num_of_words;
    logic          tx__cfg__busy;
    logic          tx__cfg__complete;
    logic          tx__cfg__error;
    logic          src__tx__valid;
    logic [DW-1:0] src__tx__data;
    logic          tx__src__ready;
    logic          tx__pe__valid;
    logic [1:0]    tx__pe__cntl;
    logic [DW-1:0] tx__pe__data;
    logic          tx__pe__parity;
    logic          pe__tx__ready;

    always #5 clk = ~clk;

    std_lane_tx_framer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .LEN_WIDTH(LW)) dut (
        .clk                   (clk),
        .reset_poweron         (reset_poweron),
        .cfg__tx__start        (cfg__tx__start),
        .cfg__tx__num_of_words (cfg__tx__num_of_words),
        .tx__cfg__busy         (tx__cfg__busy),
        .tx__cfg__complete     (tx__cfg__complete),
        .tx__cfg__error        (tx__cfg__error),
        .src__tx__valid        (src__tx__valid),
        .src__tx__data         (src__tx__data),
        .tx__src__ready        (tx__src__ready),
        .tx__pe__valid         (tx__pe__valid),
        .tx__pe__cntl          (tx__pe__cntl),
        .tx__pe__data          (tx__pe__data),
        .tx__pe__parity        (tx__pe__parity),
        .pe__tx__ready         (pe__tx__ready)
    );

    typedef struct packed {
        logic [1:0]    cntl;
        logic [DW-1:0] data;
        logic          par;
        logic          last;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] words_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  hs_cnt = 0;
    int  cmpl_cnt = 0;
    int  cyc = 0;
    int  hold_until = 0;
    bit  rand_pe = 1'b0;
    bit  src_gaps = 1'b0;
    bit  abort = 1'b0;
    bit  mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference framing rules.
    function automatic logic [1:0] cntl_of(input int i, input int n);
        if (n == 1) return 2'b00;
        if (i == 0) return 2'b01;
        if (i == n - 1) return 2'b11;
        return 2'b10;
    endfunction

    function automatic logic par_of(input logic [1:0] c, input logic [DW-1:0] d);
`ifdef STD_LANE_TX_PARITY_EN
        int ones;
        ones = $countones(c) + $countones(d);
        return ones[0];
`else
        return 1'b0;
`endif
    endfunction

    // PE ready driver: held low until hold_until, else always or randomly high.
    initial begin
        pe__tx__ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc < hold_until) pe__tx__ready = 1'b0;
            else if (rand_pe)     pe__tx__ready = 1'($urandom_range(0, 1));
            else                  pe__tx__ready = 1'b1;
        end
    end

    // Monitor: sampled at the falling edge, describing the next rising edge.
    initial begin
        bit            lhp = 1'b0;
        bit            rp  = 1'b1;
        bit            pv  = 1'b0;
        bit            pr  = 1'b0;
        logic [1:0]    pc  = '0;
        logic [DW-1:0] pd  = '0;
        logic          pp  = 1'b0;
        bit            hs;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("complete_timing", tx__cfg__complete, lhp && !rp);
                if (pv && !pr && !rp) begin
                    chk("stall_valid", tx__pe__valid, 1);
                    chk("stall_cntl", tx__pe__cntl, pc);
                    chk("stall_data", tx__pe__data, pd);
                    chk("stall_parity", tx__pe__parity, pp);
                end
                hs  = tx__pe__valid && pe__tx__ready && !reset_poweron;
                lhp = 1'b0;
                if (reset_poweron) begin
                    sb_q.delete();
                end else if (hs) begin
                    hs_cnt++;
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got data %0h, none expected", tx__pe__data);
                    end else begin
                        e = sb_q.pop_front();
                        chk("word_cntl", tx__pe__cntl, e.cntl);
                        chk("word_data", tx__pe__data, e.data);
                        chk("word_parity", tx__pe__parity, e.par);
                        lhp = e.last;
                    end
                end
                if (tx__cfg__complete) cmpl_cnt++;
                pv = tx__pe__valid;
                pr = pe__tx__ready;
                pc = tx__pe__cntl;
                pd = tx__pe__data;
                pp = tx__pe__parity;
                rp = reset_poweron;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, tx__cfg__busy, 0);
        chk({tag, "_complete"}, tx__cfg__complete, 0);
        chk({tag, "_error"}, tx__cfg__error, 0);
        chk({tag, "_src_ready"}, tx__src__ready, 0);
        chk({tag, "_pe_valid"}, tx__pe__valid, 0);
        chk({tag, "_pe_cntl"}, tx__pe__cntl, 0);
        chk({tag, "_pe_data"}, tx__pe__data, 0);
        chk({tag, "_pe_parity"}, tx__pe__parity, 0);
    endtask

    task automatic pulse_start(input int n, input bit exp_err, input bit exp_busy);
        cfg__tx__start        = 1'b1;
        cfg__tx__num_of_words = LW'(n);
        tick();
        cfg__tx__start = 1'b0;
        @(negedge clk);
        chk("start_error", tx__cfg__error, exp_err);
        chk("start_busy", tx__cfg__busy, exp_busy);
        tick();
        @(negedge clk);
        chk("error_clear", tx__cfg__error, 0);
        tick();
    endtask

    task automatic send_words();
        int idx = 0;
        int budget = 0;
        bit acc;
        while (idx < words_q.size() && !abort && budget < 500) begin
            src__tx__valid = src_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            src__tx__data  = words_q[idx];
            @(negedge clk);
            acc = src__tx__valid && tx__src__ready;
            tick();
            if (acc) idx++;
            budget++;
        end
        src__tx__valid = 1'b0;
        if (!abort && idx < words_q.size()) begin
            n_vec++;
            n_err++;
            $display("FAIL src_timeout: accepted %0d words, required %0d", idx, words_q.size());
        end
    endtask

    task automatic wait_complete();
        int target = cmpl_cnt + 1;
        int k = 0;
        while (cmpl_cnt < target && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("complete_seen", cmpl_cnt >= target, 1);
        chk("busy_during_complete", tx__cfg__busy, 1);
        @(negedge clk);
        chk("busy_after_complete", tx__cfg__busy, 0);
        chk("complete_single", tx__cfg__complete, 0);
        tick();
    endtask

    task automatic push_expected(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cntl = cntl_of(i, n);
            e.data = words_q[i];
            e.par  = par_of(e.cntl, e.data);
            e.last = (i == n - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic run_transfer(input int n, input int hold, input bit rnd_words, input bit dup_start);
        if (rnd_words) begin
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
        end
        push_expected(n);
        if (hold > 0) hold_until = cyc + hold;
        pulse_start(n, 1'b0, 1'b1);
        if (dup_start) pulse_start(n + 3, 1'b1, 1'b1);
        fork
            send_words();
            if (hold > 0) begin
                repeat (6) @(negedge clk);
                chk("full_src_ready", tx__src__ready, 0);
                chk("full_pe_valid", tx__pe__valid, 1);
                chk("full_head_data", tx__pe__data, words_q[0]);
                chk("full_head_cntl", tx__pe__cntl, 2'b01);
            end
        join
        if (n == 1) begin
            @(negedge clk);
            chk("latency_valid", tx__pe__valid, 1);
            chk("latency_data", tx__pe__data, words_q[0]);
        end
        wait_complete();
    endtask

    initial begin
        int base;
        int k;
        reset_poweron         = 1'b1;
        cfg__tx__start        = 1'b0;
        cfg__tx__num_of_words = '0;
        src__tx__valid        = 1'b0;
        src__tx__data         = '0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        reset_poweron = 1'b0;
        mon_en        = 1'b1;
        tick();

        // Single-word transfer.
        words_q = {32'hDEADBEEF};
        run_transfer(1, 0, 1'b0, 1'b0);

        // Four words, both sides always ready.
        words_q = {32'd1, 32'd2, 32'd3, 32'd4};
        run_transfer(4, 0, 1'b0, 1'b0);

        // Eight words against a stalled PE.
        run_transfer(8, 11, 1'b1, 1'b0);

        // Zero-length start is rejected.
        pulse_start(0, 1'b1, 1'b0);
        @(negedge clk);
        chk("zero_len_busy", tx__cfg__busy, 0);
        tick();

        // Second start during an active transfer is rejected and harmless.
        run_transfer(4, 0, 1'b1, 1'b1);

        // Parity vectors.
        words_q = {32'h00000001};
        run_transfer(1, 0, 1'b0, 1'b0);
        words_q = {32'h00000005, 32'h00000003};
        run_transfer(2, 0, 1'b0, 1'b0);

        // Reset after two of six words delivered.
        words_q.delete();
        for (int i = 0; i < 6; i++) words_q.push_back($urandom);
        push_expected(6);
        base = hs_cnt;
        pulse_start(6, 1'b0, 1'b1);
        fork
            send_words();
        join_none
        k = 0;
        while (hs_cnt < base + 2 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("reset_mid_progress", hs_cnt >= base + 2, 1);
        tick();
        reset_poweron = 1'b1;
        abort         = 1'b1;
        tick();
        reset_poweron = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        wait fork;
        abort = 1'b0;
        tick();
        repeat (3) tick();
        chk("midreset_no_complete", tx__cfg__complete, 0);
        run_transfer(2, 0, 1'b1, 1'b0);

        // Randomized transfers with source gaps and PE back-pressure.
        rand_pe  = 1'b1;
        src_gaps = 1'b1;
        for (int t = 0; t < 6; t++) begin
            run_transfer($urandom_range(1, 12), 0, 1'b1, 1'b0);
        end

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
